// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int MIN_LATENCY = 1;
  localparam int BYTE_W      = 8;
  localparam int LANES       = 4;

  // True when the word index of a byte address lies inside the array.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth_words);
    return {2'b00, addr[31:2]} < depth_words;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage split into byte lanes, with byte-enable writes and a
// registered read that only updates when the port is enabled.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic [LANES-1:0]               we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BYTE_W-1:0] mem [DEPTH_WORDS];
      logic [BYTE_W-1:0] rdata_q;

      // Read-before-write: a store returns the old byte, which the top discards.
      always_ff @(posedge clk_i) begin
        if (en_i) begin
          if (we_i[gi]) begin
            mem[addr_i] <= wdata_i[gi*BYTE_W +: BYTE_W];
          end
          rdata_q <= mem[addr_i];
        end
      end

      assign rdata_o[gi*BYTE_W +: BYTE_W] = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with fixed latency, valid/ready request side, a single
// response pulse and a pipeline stall output. One request outstanding at most.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (LATENCY > MIN_LATENCY) ? CNT_W'(LATENCY - 2) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             load_ok_q, load_ok_d;

  logic             in_idle;
  logic             commit;
  logic             cur_write;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic             req_err;
  logic [31:0]      arr_rdata;

  assign in_idle = (state_q == ST_IDLE);

  // With single-cycle latency the commit coincides with the accept edge, so
  // the live request must be used instead of the not-yet-loaded latch.
  assign cur_write = in_idle ? req_write_i : write_q;
  assign cur_addr  = in_idle ? req_addr_i  : addr_q;
  assign cur_wdata = in_idle ? req_wdata_i : wdata_q;
  assign cur_be    = in_idle ? req_be_i    : be_q;

  assign req_err = (cur_addr[1:0] != 2'b00) || !addr_in_range(cur_addr, DEPTH_WORDS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_err_d   = rsp_err_q;
    load_ok_d   = load_ok_q;
    commit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          if (LATENCY == MIN_LATENCY) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = commit;
    if (commit) begin
      rsp_err_d = req_err;
      load_ok_d = !req_err && !cur_write;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      load_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      load_ok_q   <= load_ok_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (commit && !req_err),
    .we_i   (cur_write ? cur_be : 4'b0000),
    .addr_i (cur_addr[AW+1:2]),
    .wdata_i(cur_wdata),
    .rdata_o(arr_rdata)
  );

  // The array read register is not reset, so gate it with a resettable flag;
  // stores and errors therefore read back as zero.
  assign rsp_rdata_o = load_ok_q ? arr_rdata : 32'h0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign req_ready_o = in_idle;
  assign stall_o     = (in_idle && req_valid_i) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 3 and LATENCY 1, scoreboard-checked.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        v3, w3, rdy3, rv3, re3, st3;
  logic [31:0] a3, wd3, rd3;
  logic [3:0]  be3;
  logic        v1, w1, rdy1, rv1, re1, st1;
  logic [31:0] a1, wd1, rd1;
  logic [3:0]  be1;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_write_i(w3),
    .req_addr_i(a3), .req_wdata_i(wd3), .req_be_i(be3),
    .rsp_valid_o(rv3), .rsp_rdata_o(rd3), .rsp_err_o(re3), .stall_o(st3)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_write_i(w1),
    .req_addr_i(a1), .req_wdata_i(wd1), .req_be_i(be1),
    .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .rsp_err_o(re1), .stall_o(st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (sel) begin
      v1 = v; w1 = wr; a1 = a; wd1 = wd; be1 = be;
    end else begin
      v3 = v; w3 = wr; a3 = a; wd3 = wd; be3 = be;
    end
  endtask

  function automatic logic g_rv(bit sel);  return sel ? rv1  : rv3;  endfunction
  function automatic logic g_rdy(bit sel); return sel ? rdy1 : rdy3; endfunction
  function automatic logic g_st(bit sel);  return sel ? st1  : st3;  endfunction
  function automatic logic g_err(bit sel); return sel ? re1  : re3;  endfunction
  function automatic logic [31:0] g_rd(bit sel); return sel ? rd1 : rd3; endfunction

  // Pops the oldest expectation and compares it with the live response.
  task automatic sb_check(input bit sel, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, g_rd(sel), e.rdata);
      chk({tag, "_err"}, 32'(g_err(sel)), 32'(e.err));
    end
  endtask

  // One complete request: accept, wait for response with a bounded loop,
  // check latency, stall length, handshake levels and scoreboard data.
  task automatic do_req(input bit sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err, input bit perturb);
    int lat;
    int stalls;
    int exp_lat;
    exp_lat = sel ? 1 : 3;
    @(negedge clk);
    drive(sel, 1'b1, wr, addr, wdata, be);
    #1;
    chk("ready_in_idle", 32'(g_rdy(sel)), 32'd1);
    stalls = g_st(sel) ? 1 : 0;
    @(posedge clk);
    sb.push_back('{exp_rd, exp_err});
    lat = 1;
    @(negedge clk);
    if (perturb) begin
      drive(sel, 1'b0, wr, addr + 32'd4, ~wdata, ~be);
    end else begin
      drive(sel, 1'b0, wr, addr, wdata, be);
    end
    #1;
    while (!g_rv(sel) && lat < 20) begin
      if (g_st(sel)) stalls++;
      @(negedge clk);
      #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("stall_cycles", 32'(stalls), 32'(exp_lat));
    chk("ready_low_in_resp", 32'(g_rdy(sel)), 32'd0);
    chk("stall_low_in_resp", 32'(g_st(sel)), 32'd0);
    $display("txn lat=%0d %s addr=%h wdata=%h be=%b rdata=%h err=%0d cycles=%0d",
             exp_lat, wr ? "store" : "load ", addr, wdata, be, g_rd(sel), g_err(sel), lat);
    sb_check(sel, "rsp");
    @(negedge clk);
    #1;
    chk("rsp_single_pulse", 32'(g_rv(sel)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("reset_ready", 32'(rdy3), 32'd1);
    chk("reset_rsp_valid", 32'(rv3), 32'd0);
    chk("reset_rdata", rd3, 32'h0);
    chk("reset_err", 32'(re3), 32'd0);
    chk("reset_stall", 32'(st3), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Preload words used later.
    do_req(1'b0, 1'b1, 32'h10,  32'h00000000, 4'hF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h0C,  32'hAABBCCDD, 4'hF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h000, 32'h01020304, 4'hF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h3FC, 32'h05060708, 4'hF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h20,  32'h20202020, 4'hF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h24,  32'h24242424, 4'hF, 32'h0, 1'b0, 1'b0);

    // Byte enables, including an all-zero enable store.
    do_req(1'b0, 1'b1, 32'h0C, 32'h00000011, 4'b0001, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, 32'hAABBCC11, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 32'h0C, 32'h0, 4'hF, 32'hAABBCC11, 1'b0, 1'b0);

    // Errors: misaligned load, out-of-range store leaves the array untouched.
    do_req(1'b0, 1'b0, 32'h06,  32'h0, 4'hF, 32'h0, 1'b1, 1'b0);
    do_req(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0);
    do_req(1'b0, 1'b0, 32'h000, 32'h0, 4'hF, 32'h01020304, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 32'h3FC, 32'h0, 4'hF, 32'h05060708, 1'b0, 1'b0);

    // Request fields changed during WAIT must be ignored.
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h20202020, 1'b0, 1'b1);

    // Store then load of the same word.
    do_req(1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 1'b0, 32'h08, 32'h0, 4'hF, 32'h11223344, 1'b0, 1'b0);

    // Reset in the middle of a store's WAIT phase.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("wait_stall_before_reset", 32'(st3), 32'd1);
    chk("wait_ready_before_reset", 32'(rdy3), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", 32'(rdy3), 32'd1);
    chk("async_reset_rsp_valid", 32'(rv3), 32'd0);
    chk("async_reset_rdata", rd3, 32'h0);
    chk("async_reset_err", 32'(re3), 32'd0);
    chk("async_reset_stall_valid_high", 32'(st3), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("async_reset_stall_valid_low", 32'(st3), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("txn lat=3 reset during WAIT of store addr=00000010 wdata=deadbeef");
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h00000000, 1'b0, 1'b0);

    // LATENCY=1: preload, then back-to-back loads with valid held high.
    do_req(1'b1, 1'b1, 32'h00, 32'h0000AAAA, 4'hF, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 1'b1, 32'h04, 32'h0000BBBB, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h00, 32'h0, 4'hF);
    #1;
    chk("b2b_first_ready", 32'(rdy1), 32'd1);
    chk("b2b_first_stall", 32'(st1), 32'd1);
    @(posedge clk);
    sb.push_back('{32'h0000AAAA, 1'b0});
    @(negedge clk);
    #1;
    chk("b2b_resp1_valid", 32'(rv1), 32'd1);
    chk("b2b_resp1_ready_low", 32'(rdy1), 32'd0);
    chk("b2b_resp1_stall_low", 32'(st1), 32'd0);
    $display("txn lat=1 b2b load addr=00000000 rdata=%h err=%0d", rd1, re1);
    sb_check(1'b1, "b2b_resp1");
    a1 = 32'h04;
    @(negedge clk);
    #1;
    chk("b2b_idle_ready", 32'(rdy1), 32'd1);
    chk("b2b_idle_no_rsp", 32'(rv1), 32'd0);
    chk("b2b_idle_stall", 32'(st1), 32'd1);
    @(posedge clk);
    sb.push_back('{32'h0000BBBB, 1'b0});
    @(negedge clk);
    #1;
    chk("b2b_resp2_valid", 32'(rv1), 32'd1);
    chk("b2b_resp2_ready_low", 32'(rdy1), 32'd0);
    $display("txn lat=1 b2b load addr=00000004 rdata=%h err=%0d", rd1, re1);
    sb_check(1'b1, "b2b_resp2");
    v1 = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_end_no_rsp", 32'(rv1), 32'd0);
    chk("b2b_end_rdata_held", rd1, 32'h0000BBBB);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
